d_latch_classifier: RTL

//  Upstream driver and downstream checker for a D-latch under test (DUT with ports d, en, q).
//  On start, it drives a fixed 5-step (en,d) sequence into the latch and samples q after each step.
//  It then classifies the latch as active-low (cfg 0) or active-high (cfg 1) enable, or flags an error.

---
 rtl/d_latch_classifier.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/d_latch_classifier.sv
// -----------------------------------------------------------------------------
// d_latch_classifier
//
// Drives a fixed five-step (en,d) sequence into an external D-latch, samples
// its q output at the end of each step and classifies the latch as
// active-high enable, active-low enable, or unrecognised.
//
// Parameters:
//   SETTLE_CYCLES  extra hold cycles per step before q is sampled (1..15)
//
// Optional build macro:
//   D_LATCH_CLASSIFY_SYNC_EN  route lat_q through a 2-flop synchroniser and
//                             lengthen each step by two cycles to cover it
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request a classification run (honoured in IDLE only)
//   lat_d      out  data driven to the latch d input
//   lat_en     out  enable driven to the latch en input
//   lat_q      in   latch q output
//   busy       out  run in progress
//   done       out  one-cycle pulse when the result is final
//   id_valid   out  sequence matched a known latch type
//   id_cfg     out  0 = active-low enable, 1 = active-high enable
//   id_error   out  sequence matched neither type (or an X/Z was sampled)
//   signature  out  sampled q for steps 1..4, signature[i-1] = step i
// -----------------------------------------------------------------------------
module d_latch_classifier #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       lat_d,
    output logic       lat_en,
    input  logic       lat_q,
    output logic       busy,
    output logic       done,
    output logic       id_valid,
    output logic       id_cfg,
    output logic       id_error,
    output logic [3:0] signature
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("d_latch_classifier: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

`ifdef D_LATCH_CLASSIFY_SYNC_EN
    // Two extra cycles per step so the synchronised sample reflects the
    // drive of the step being sampled rather than the previous one.
    localparam int HOLD_CYCLES = SETTLE_CYCLES + 3;
`else
    localparam int HOLD_CYCLES = SETTLE_CYCLES + 1;
`endif

    localparam logic [4:0] RELOAD = 5'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DECIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  step;
    logic [4:0]  settle_cnt;
    logic        bad;
    logic        q_sample;
    logic [1:0]  sig_idx;

    // Signature slot for the step currently being sampled (steps 1..4).
    assign sig_idx = 2'(step - 3'd1);

`ifdef D_LATCH_CLASSIFY_SYNC_EN
    logic q_meta;
    logic q_sync;

    // Plain two-flop synchroniser for the asynchronous latch output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_meta <= 1'b0;
            q_sync <= 1'b0;
        end else begin
            q_meta <= lat_q;
            q_sync <= q_meta;
        end
    end

    assign q_sample = q_sync;
`else
    assign q_sample = lat_q;
`endif

    // Drive table, returned as {en, d}.
    function automatic logic [1:0] drive_of(input logic [2:0] s);
        logic [1:0] v;
        case (s)
            3'd0:    v = 2'b00;
            3'd1:    v = 2'b10;
            3'd2:    v = 2'b11;
            3'd3:    v = 2'b01;
            default: v = 2'b00;
        endcase
        return v;
    endfunction

    // Main sequencer: walks the drive table, collects samples, classifies,
    // then pulses done. All outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step       <= 3'd0;
            settle_cnt <= 5'd0;
            bad        <= 1'b0;
            lat_en     <= 1'b0;
            lat_d      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            id_valid   <= 1'b0;
            id_cfg     <= 1'b0;
            id_error   <= 1'b0;
            signature  <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    lat_en <= 1'b0;
                    lat_d  <= 1'b0;
                    if (start) begin
                        state           <= RUN;
                        step            <= 3'd0;
                        settle_cnt      <= RELOAD;
                        bad             <= 1'b0;
                        busy            <= 1'b1;
                        id_valid        <= 1'b0;
                        id_error        <= 1'b0;
                        signature       <= 4'd0;
                        {lat_en, lat_d} <= drive_of(3'd0);
                    end
                end

                RUN: begin
                    if (settle_cnt != 5'd0) begin
                        settle_cnt <= settle_cnt - 5'd1;
                    end else begin
                        // Step 0 only initialises the latch; its sample is dropped.
                        // An unknown sample is stored as 0 and poisons the result.
                        if (step != 3'd0) begin
                            if ($isunknown(q_sample)) begin
                                signature[sig_idx] <= 1'b0;
                                bad                <= 1'b1;
                            end else begin
                                signature[sig_idx] <= q_sample;
                            end
                        end
                        if (step == 3'd4) begin
                            state  <= DECIDE;
                            lat_en <= 1'b0;
                            lat_d  <= 1'b0;
                        end else begin
                            step            <= step + 3'd1;
                            settle_cnt      <= RELOAD;
                            {lat_en, lat_d} <= drive_of(step + 3'd1);
                        end
                    end
                end

                DECIDE: begin
                    state <= DONE;
                    if (!bad && signature == 4'b1110) begin
                        id_valid <= 1'b1;
                        id_cfg   <= 1'b1;
                    end else if (!bad && signature == 4'b0100) begin
                        id_valid <= 1'b1;
                        id_cfg   <= 1'b0;
                    end else begin
                        id_error <= 1'b1;
                        id_cfg   <= 1'b0;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
